// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader.
//   HALT_WORD_DEFAULT : end-of-program marker (stored, then loading stops)
//   NOP_INSTR         : value returned for out-of-range fetch addresses
//   load_state_e      : loader FSM state encoding
package imem_loader_pkg;

  localparam logic [31:0] HALT_WORD_DEFAULT = 32'hFFFF_FFFF;
  localparam logic [31:0] NOP_INSTR         = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DONE  = 2'd2,
    ST_ERROR = 2'd3
  } load_state_e;

endpackage

// File: rtl/imem_ram.sv
// DEPTH x 32 instruction storage.
//   clk   : write clock (rising edge)
//   we    : write enable
//   waddr : word index written on the edge
//   wdata : word written
//   raddr : word index read combinationally
//   rdata : word at raddr; a same-cycle write shows up only after the edge
module imem_ram #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [31:0]       wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [31:0]       rdata
);

  logic [31:0] mem [DEPTH];

  // NOTE: the array has no reset; a program survives a reset pulse and the
  // storage maps onto plain RAM without per-word clear logic.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/imem_loader.sv
// Instruction memory with a byte-stream program loader.
// Bytes are packed little-endian into 32-bit words and written from word 0
// upward until the halt word is stored (DONE) or the array overflows (ERROR).
//   clk          : clock, rising edge
//   reset        : asynchronous, active-low reset
//   i_start      : pulse; starts a (re)load in any state
//   i_byte_valid : i_byte_data valid this cycle
//   i_byte_data  : program byte
//   i_pc         : fetch byte address
//   o_instr      : instruction at i_pc (combinational, NOP if out of range)
//   o_cpu_stall  : high unless a load has completed successfully
//   o_load_done  : high in DONE
//   o_load_error : high in ERROR (overflow)
//   o_word_count : words written by the current/last load, saturates at DEPTH
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int          DEPTH     = 256,
  parameter int          ADDR_W    = 8,
  parameter logic [31:0] HALT_WORD = HALT_WORD_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_start,
  input  logic            i_byte_valid,
  input  logic [7:0]      i_byte_data,
  input  logic [31:0]     i_pc,
  output logic [31:0]     o_instr,
  output logic            o_cpu_stall,
  output logic            o_load_done,
  output logic            o_load_error,
  output logic [ADDR_W:0] o_word_count
);

  localparam logic [ADDR_W-1:0] PTR_LAST  = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   COUNT_MAX = (ADDR_W + 1)'(DEPTH);

  load_state_e       state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [1:0]        lane_q, lane_d;
  logic [23:0]       asm_q, asm_d;
  logic [ADDR_W:0]   count_q, count_d;

  logic              we;
  logic [31:0]       word;
  logic [31:0]       rdata;

  // The word completing this cycle, used only when lane_q == 3.
  assign word = {i_byte_data, asm_q};

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge value of its neighbours.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      lane_q  <= '0;
      asm_q   <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      lane_q  <= lane_d;
      asm_q   <= asm_d;
      count_q <= count_d;
    end
  end

  // NOTE: every output of this block is given a default first so no path
  // leaves a variable unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    lane_d  = lane_q;
    asm_d   = asm_q;
    count_d = count_q;
    we      = 1'b0;

    if (i_start) begin
      // Start/restart wins over a byte arriving in the same cycle.
      state_d = ST_LOAD;
      ptr_d   = '0;
      lane_d  = '0;
      asm_d   = '0;
      count_d = '0;
    end else if (state_q == ST_LOAD && i_byte_valid) begin
      if (lane_q == 2'd3) begin
        we      = 1'b1;
        ptr_d   = ptr_q + 1'b1;
        lane_d  = '0;
        asm_d   = '0;
        count_d = (count_q == COUNT_MAX) ? count_q : count_q + 1'b1;
        // A halt word in the last slot is a clean finish, not an overflow.
        if (word == HALT_WORD)      state_d = ST_DONE;
        else if (ptr_q == PTR_LAST) state_d = ST_ERROR;
      end else begin
        lane_d = lane_q + 1'b1;
        case (lane_q)
          2'd0:    asm_d[7:0]   = i_byte_data;
          2'd1:    asm_d[15:8]  = i_byte_data;
          default: asm_d[23:16] = i_byte_data;
        endcase
      end
    end
  end

  imem_ram #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .we    (we),
    .waddr (ptr_q),
    .wdata (word),
    .raddr (i_pc[ADDR_W+1:2]),
    .rdata (rdata)
  );

  // Byte offset within a word is irrelevant for word fetches.
  logic unused_pc_lsb;
  assign unused_pc_lsb = ^i_pc[1:0];

  assign o_instr      = (|i_pc[31:ADDR_W+2]) ? NOP_INSTR : rdata;
  assign o_cpu_stall  = (state_q != ST_DONE);
  assign o_load_done  = (state_q == ST_DONE);
  assign o_load_error = (state_q == ST_ERROR);
  assign o_word_count = count_q;

endmodule
